conv_frame_ctrl: RTL
====================

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 12: input pixel width.
REQ-002 Parameter IMG_W, default 640: pixels per line, minimum 3.
REQ-003 Parameter IMG_H, default 480: lines per frame, minimum 3.
REQ-004 Parameter CONV_LAT, default 1: convolution datapath latency in cycles, range 1 to 4.
REQ-005 i_clk  in  1  clock; all logic on rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_start  in  1  single-cycle frame start request.
REQ-008 i_mode_horizontal  in  1  filter select; sampled at frame start.
REQ-009 i_pix_valid  in  1  input pixel strobe.
REQ-010 i_pix  in  DATA_WIDTH  input pixel, raster order.
REQ-011 o_conv_valid  out  1  pixel strobe to the convolution datapath.
REQ-012 o_conv_pix  out  DATA_WIDTH  pixel to the convolution datapath.
REQ-013 o_conv_horizontal  out  1  filter select to the convolution datapath.
REQ-014 i_conv_valid  in  1  result strobe from the convolution datapath.
REQ-015 i_conv_val  in  18  unsigned result from the convolution datapath.
REQ-016 o_out_valid  out  1  output pixel strobe.
REQ-017 o_out_val  out  DATA_WIDTH  masked, saturated output pixel.
REQ-018 o_busy  out  1  high in RUN and DRAIN.
REQ-019 o_frame_done  out  1  single-cycle pulse after the last output pixel.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-021 IDLE: i_start high -> RUN; on the same edge latch i_mode_horizontal and clear col, row and out_cnt.
REQ-022 IDLE/DONE: i_pix_valid ignored; o_conv_valid held 0.
REQ-023 RUN: i_start ignored; mode latch held constant; o_conv_horizontal = latched mode in every state.
REQ-024 RUN: o_conv_valid = i_pix_valid; o_conv_pix = i_pix (combinational pass-through, zero latency).
REQ-025 RUN: each accepted pixel increments col; col = IMG_W-1 wraps to 0 and increments row.
REQ-026 RUN: accepted pixel at row IMG_H-1, col IMG_W-1 -> DRAIN on the next edge.
REQ-027 Border flag per accepted pixel: set when row < 2 or col < 2, i.e. the 3x3 window is incomplete.
REQ-028 Border flag enters a CONV_LAT-deep shift pipe that advances every cycle; an empty slot carries flag 0.
REQ-029 Output stage is active in RUN and DRAIN: o_out_valid = i_conv_valid.
REQ-030 Output value: delayed border flag set -> 0; otherwise min(i_conv_val, 2^DATA_WIDTH-1) (unsigned saturation).
REQ-031 Outside RUN/DRAIN: o_out_valid = 0 and i_conv_valid is ignored.
REQ-032 out_cnt increments on each o_out_valid; counter width is ceil(log2(IMG_W*IMG_H+1)).
REQ-033 Output pixel count per frame equals IMG_W*IMG_H; border pixels are emitted as 0, not dropped.
REQ-034 DRAIN: out_cnt reaching IMG_W*IMG_H -> DONE; this includes the case where it completes on the same edge as the RUN->DRAIN transition.
REQ-035 DONE: o_frame_done = 1 for exactly one cycle, then IDLE.
REQ-036 i_start asserted in DONE is ignored; a new frame requires i_start in IDLE.
REQ-037 o_out_val and o_conv_pix are 0 whenever the matching valid is 0.

Reset
REQ-038 Reset asserted: state IDLE, counters 0, border pipe 0, mode latch 0.
REQ-039 Reset asserted: o_conv_valid, o_out_valid, o_busy, o_frame_done, o_conv_horizontal all 0.
REQ-040 Reset mid-frame aborts the frame immediately: no o_frame_done, and a new frame starts only with i_start after release.

Verification
REQ-041 IMG_W=4, IMG_H=3, CONV_LAT=1, i_start, mode=1, 12 back-to-back pixels of 100 with i_conv_val looped from a 1-cycle model returning 50 -> 12 outputs; only indices 10 and 11 are 50, all others 0; o_frame_done pulses once, one cycle after output 12.
REQ-042 Same frame with i_pix_valid toggling every other cycle -> col/row advance only on valid, identical output sequence, o_busy high throughout.
REQ-043 i_conv_val = 5000 on a non-border pixel -> o_out_val = 4095; i_conv_val = 4095 -> 4095.
REQ-044 i_mode_horizontal changed 1->0 mid-frame, i_start pulsed mid-frame -> o_conv_horizontal stays 1 and the frame completes normally.
REQ-045 Pixels presented in IDLE before i_start -> o_conv_valid = 0 and out_cnt = 0.
REQ-046 Reset asserted after pixel 6 of 12 -> all outputs 0 immediately; after release, i_start and 12 pixels -> a normal complete frame.

Source files
------------

// File: rtl/conv_frame_ctrl_if.sv
// Pixel-in, convolution-datapath and pixel-out buses of the frame controller.
// The slave modport is the controller; master is the surrounding system.
interface conv_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 12
) ();

  logic                  i_pix_valid;
  logic [DATA_WIDTH-1:0] i_pix;
  logic                  o_conv_valid;
  logic [DATA_WIDTH-1:0] o_conv_pix;
  logic                  o_conv_horizontal;
  logic                  i_conv_valid;
  logic [17:0]           i_conv_val;
  logic                  o_out_valid;
  logic [DATA_WIDTH-1:0] o_out_val;

  modport slave (
    input  i_pix_valid, i_pix, i_conv_valid, i_conv_val,
    output o_conv_valid, o_conv_pix, o_conv_horizontal, o_out_valid, o_out_val
  );

  modport master (
    output i_pix_valid, i_pix, i_conv_valid, i_conv_val,
    input  o_conv_valid, o_conv_pix, o_conv_horizontal, o_out_valid, o_out_val
  );

endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer around an external 3x3 convolution datapath: tracks raster
// position, masks incomplete-window results to 0 and saturates the rest.
module conv_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned CONV_LAT   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode_horizontal,
  output logic              o_busy,
  output logic              o_frame_done,
  conv_frame_ctrl_if.slave  bus
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [17:0]      SAT_MAX   = 18'((64'd1 << DATA_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic                mode_q;
  logic [CONV_LAT-1:0] pipe_q;

  logic                start_c;
  logic                accept_c;
  logic                border_c;
  logic                out_valid_c;
  logic                flag_dly_c;
  logic [CNT_W-1:0]    out_cnt_nxt_c;
  logic [CONV_LAT:0]   pipe_in_c;
  logic [DATA_WIDTH-1:0] sat_c;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          start_c = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        accept_c = bus.i_pix_valid;
        if (bus.i_pix_valid && (col_q == LAST_COL) && (row_q == LAST_ROW)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Covers a count that already completed when DRAIN was entered.
        if (out_cnt_nxt_c == TOTAL_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign border_c      = (row_q < ROW_W'(2)) || (col_q < COL_W'(2));
  assign out_valid_c   = bus.i_conv_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign out_cnt_nxt_c = out_cnt_q + CNT_W'(out_valid_c && (out_cnt_q != TOTAL_CNT));

  // Border flag travels alongside the pixel through the datapath latency.
  assign pipe_in_c  = {pipe_q, accept_c & border_c};
  assign flag_dly_c = pipe_q[CONV_LAT-1];

  // Raster position, output count, mode latch and border pipe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      mode_q    <= 1'b0;
      pipe_q    <= '0;
    end else begin
      pipe_q <= pipe_in_c[CONV_LAT-1:0];
      if (start_c) begin
        col_q     <= '0;
        row_q     <= '0;
        out_cnt_q <= '0;
        mode_q    <= i_mode_horizontal;
      end else begin
        out_cnt_q <= out_cnt_nxt_c;
        if (accept_c) begin
          if (col_q == LAST_COL) begin
            col_q <= '0;
            row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
      end
    end
  end

  assign sat_c = (bus.i_conv_val > SAT_MAX) ? DATA_WIDTH'(SAT_MAX)
                                            : DATA_WIDTH'(bus.i_conv_val);

  assign bus.o_conv_valid      = accept_c;
  assign bus.o_conv_pix        = accept_c ? bus.i_pix : '0;
  assign bus.o_conv_horizontal = mode_q;
  assign bus.o_out_valid       = out_valid_c;
  assign bus.o_out_val         = (out_valid_c && !flag_dly_c) ? sat_c : '0;
  assign o_busy                = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign o_frame_done          = (state_q == S_DONE);

endmodule
